mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage directly downstream of the EXE/MEM register; consumes its outputs.
- Drives the data-memory bus using a request/grant/rvalid handshake. Aligns and sign-extends load data and builds store byte-enables.
- Selects the writeback value and registers it into MEM/WB outputs.
- Asserts stall to freeze IF..EXE/MEM while a memory access is outstanding.

Parameters:
- TIMEOUT, 255, cycles spent in REQ+WAIT before an access is aborted with bus_err.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alures_in  input  32  ALU result / memory address.
- MemWHB_in  input  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes treated as 010.
- MemReWr_in  input  2  01 load, 10 store, 00 or 11 no access.
- RegVal2_in  input  32  store data.
- alu_res_pc4_in  input  1  1 = writeback pcadd4 (JAL/JALR).
- pcadd4_in  input  32  PC+4.
- RegWrite_in  input  1  register-file write enable.
- RdAddr_in  input  5  destination register.
- CSR_sel_in  input  1  forwarded to WB unchanged.
- instr_in  input  32  instruction word, forwarded.
- dmem_req  output  1  bus request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  32  word address: {alures_in[31:2],2'b00}.
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  store data, lane-replicated.
- dmem_gnt  input  1  request accepted this cycle.
- dmem_rvalid  input  1  read data valid this cycle.
- dmem_rdata  input  32  read data.
- stall  output  1  holds upstream stages; combinational.
- bus_err  output  1  one-cycle pulse on timeout.
- misalign_exc  output  1  one-cycle pulse on a misaligned access.
- wb_data_out  output  32  registered writeback value.
- RegWrite_out / RdAddr_out / CSR_sel_out / instr_out  output  1/5/1/32  registered MEM/WB fields.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, the counter clears, and every registered output is 0. Combinational outputs must be 0 while in reset.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, no access: stall=0. MEM/WB registers load at the next edge (1-cycle latency).
  - IDLE, access present: dmem_req=1 in the same cycle.
    - gnt=1 and store: retire this cycle with stall=0; stay in IDLE.
    - gnt=1 and load: go to WAIT with stall=1.
    - gnt=0: go to REQ with stall=1.
  - REQ: dmem_req=1, stall=1. On gnt: store retires (stall=0) and returns to IDLE; load goes to WAIT.
  - WAIT: dmem_req=0. On rvalid: stall=0, load data is captured into wb_data_out at this edge, return to IDLE.
- rvalid in the same cycle as gnt is illegal; the bus guarantees rvalid no earlier than one cycle after gnt.
- Upstream holds all *_in values stable while stall=1.
- Bus outputs (req/we/addr/be/wdata) are combinational from *_in and hold steady while in REQ.
- Store byte-enables:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{RegVal2[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{RegVal2[15:0]}}.
  - SW: be = 4'b1111, wdata = RegVal2.
- Loads: shift rdata right by 8*addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. dmem_be follows the same pattern as stores.
- Writeback select: alu_res_pc4_in ? pcadd4_in : (load ? aligned data : alures_in).
- Timeout counter: increments every cycle in REQ/WAIT and clears in IDLE. When count == TIMEOUT:
  - bus_err pulses for one cycle and the instruction retires with RegWrite_out=0.
  - FSM returns to IDLE; any late rvalid is ignored.
- Reset mid-access: FSM returns to IDLE immediately and the pending request is dropped.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠00, issues no request. misalign_exc pulses for one cycle, the instruction retires in one cycle with RegWrite_out=0, and stall stays 0.
- Undefined: misalign_exc is tied 0. Low address bits are forced to zero for the access size (halfword addr[0]=0, word addr[1:0]=00) and the access proceeds normally.

Test Plan:
- ALU op, alures_in=0x1234, RegWrite_in=1, RdAddr_in=5, no access → next edge: wb_data_out=0x1234, RdAddr_out=5, stall never 1.
- SB, addr=0x103, RegVal2_in=0xAB, gnt=1 in the first cycle → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, stall=0.
- LB, addr=0x102, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x0080_0000 → stall high for 5 cycles, wb_data_out=0xFFFFFF80. The same sequence as LBU gives 0x80.
- JAL retire with alu_res_pc4_in=1, pcadd4_in=0x44 → wb_data_out=0x44.
- Load granted, no rvalid for TIMEOUT=255 cycles → bus_err single pulse, RegWrite_out=0, FSM back in IDLE; a late rvalid has no effect.
- LW at 0x102: with MISALIGN_TRAP_EN → misalign_exc pulse, no dmem_req, RegWrite_out=0. Without it → dmem_addr=0x100, be=1111. Also: rst low while in WAIT → all outputs 0, IDLE.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Request/grant/rvalid handshake; read data arrives no earlier than one cycle after grant.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data bus, aligns load data and registers the MEM/WB fields.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of forcing alignment.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          alures_in,
  input  logic [2:0]           MemWHB_in,
  input  logic [1:0]           MemReWr_in,
  input  logic [31:0]          RegVal2_in,
  input  logic                 alu_res_pc4_in,
  input  logic [31:0]          pcadd4_in,
  input  logic                 RegWrite_in,
  input  logic [4:0]           RdAddr_in,
  input  logic                 CSR_sel_in,
  input  logic [31:0]          instr_in,
  mem_access_stage_if.master   dmem,
  output logic                 stall,
  output logic                 bus_err,
  output logic                 misalign_exc,
  output logic [31:0]          wb_data_out,
  output logic                 RegWrite_out,
  output logic [4:0]           RdAddr_out,
  output logic                 CSR_sel_out,
  output logic [31:0]          instr_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;

  size_t       size;
  logic        zext;
  logic        is_load;
  logic        is_store;
  logic        access;
  logic        trap;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] aligned;
  logic        timeout;
  logic        req_c;
  logic        stall_c;
  logic        err_c;
  logic        load_done;

  assign is_load  = (MemReWr_in == 2'b01);
  assign is_store = (MemReWr_in == 2'b10);
  assign access   = is_load | is_store;
  assign timeout  = (cnt == CNT_W'(TIMEOUT));

  always_comb begin
    size = SZ_W;
    zext = 1'b0;
    case (MemWHB_in)
      3'b000:  size = SZ_B;
      3'b001:  size = SZ_H;
      3'b100:  begin size = SZ_B; zext = 1'b1; end
      3'b101:  begin size = SZ_H; zext = 1'b1; end
      default: size = SZ_W;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = access && ((size == SZ_H && alures_in[0]) ||
                           (size == SZ_W && alures_in[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Byte lane of the access; low bits below the access size are ignored.
  always_comb begin
    case (size)
      SZ_B:    lane = alures_in[1:0];
      SZ_H:    lane = {alures_in[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  always_comb begin
    case (size)
      SZ_B: begin
        be    = 4'b0001 << lane;
        wdata = {4{RegVal2_in[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << lane;
        wdata = {2{RegVal2_in[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = RegVal2_in;
      end
    endcase
  end

  assign shifted = dmem.dmem_rdata >> {lane, 3'b000};

  always_comb begin
    case (size)
      SZ_B:    aligned = zext ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    aligned = zext ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  // Handshake control; a completing grant/rvalid wins over a simultaneous timeout.
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: begin
        if (access && !trap) begin
          req_c = 1'b1;
          if (dmem.dmem_gnt) begin
            if (is_load) begin
              state_next = WAIT;
              stall_c    = 1'b1;
            end
          end else begin
            state_next = REQ;
            stall_c    = 1'b1;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (dmem.dmem_gnt) begin
          if (is_load) begin
            state_next = WAIT;
            stall_c    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (timeout) begin
          state_next = IDLE;
          err_c      = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
          err_c      = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_done = (state == WAIT) && dmem.dmem_rvalid;

  // Everything combinational is forced quiet while reset is held.
  assign stall           = rst & stall_c;
  assign dmem.dmem_req   = rst & req_c;
  assign dmem.dmem_we    = rst & is_store;
  assign dmem.dmem_addr  = rst ? {alures_in[31:2], 2'b00} : 32'b0;
  assign dmem.dmem_be    = rst ? be : 4'b0;
  assign dmem.dmem_wdata = rst ? wdata : 32'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus_err      <= 1'b0;
      wb_data_out  <= 32'b0;
      RegWrite_out <= 1'b0;
      RdAddr_out   <= 5'b0;
      CSR_sel_out  <= 1'b0;
      instr_out    <= 32'b0;
    end else begin
      state   <= state_next;
      cnt     <= (state == IDLE) ? '0 : cnt + 1'b1;
      bus_err <= err_c;
      if (!stall_c) begin
        wb_data_out  <= alu_res_pc4_in ? pcadd4_in : (load_done ? aligned : alures_in);
        RegWrite_out <= RegWrite_in & ~err_c & ~trap;
        RdAddr_out   <= RdAddr_in;
        CSR_sel_out  <= CSR_sel_in;
        instr_out    <= instr_in;
      end else begin
        // Bubble into WB while the access is outstanding.
        RegWrite_out <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= (state == IDLE) && trap;
    end
  end
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a scoreboard of expected MEM/WB records.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alures_in;
  logic [2:0]  MemWHB_in;
  logic [1:0]  MemReWr_in;
  logic [31:0] RegVal2_in;
  logic        alu_res_pc4_in;
  logic [31:0] pcadd4_in;
  logic        RegWrite_in;
  logic [4:0]  RdAddr_in;
  logic        CSR_sel_in;
  logic [31:0] instr_in;
  logic        stall;
  logic        bus_err;
  logic        misalign_exc;
  logic [31:0] wb_data_out;
  logic        RegWrite_out;
  logic [4:0]  RdAddr_out;
  logic        CSR_sel_out;
  logic [31:0] instr_out;

  always #5 clk = ~clk;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(255), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .alures_in      (alures_in),
    .MemWHB_in      (MemWHB_in),
    .MemReWr_in     (MemReWr_in),
    .RegVal2_in     (RegVal2_in),
    .alu_res_pc4_in (alu_res_pc4_in),
    .pcadd4_in      (pcadd4_in),
    .RegWrite_in    (RegWrite_in),
    .RdAddr_in      (RdAddr_in),
    .CSR_sel_in     (CSR_sel_in),
    .instr_in       (instr_in),
    .dmem           (bus),
    .stall          (stall),
    .bus_err        (bus_err),
    .misalign_exc   (misalign_exc),
    .wb_data_out    (wb_data_out),
    .RegWrite_out   (RegWrite_out),
    .RdAddr_out     (RdAddr_out),
    .CSR_sel_out    (CSR_sel_out),
    .instr_out      (instr_out)
  );

  typedef struct {
    logic [31:0] alures;
    logic [2:0]  whb;
    logic [1:0]  rw;
    logic [31:0] val2;
    logic        pc4;
    logic [31:0] pcadd4;
    logic        regwrite;
    logic [4:0]  rd;
    logic        csr;
    int          gnt_cyc;
    int          rv_cyc;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_stall;
    logic [31:0] exp_wb;
    logic        exp_regwrite;
    logic        exp_mis;
    logic        chk_wb;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic        regwrite;
    logic [4:0]  rd;
    logic        csr;
    logic [31:0] instr;
    logic        err;
    logic        mis;
    logic        chk_wb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected a pending record");
    end else begin
      e = sb.pop_front();
      if (e.chk_wb) chk("wb_data_out", wb_data_out, e.wb);
      chk("RegWrite_out", 32'(RegWrite_out), 32'(e.regwrite));
      chk("RdAddr_out", 32'(RdAddr_out), 32'(e.rd));
      chk("CSR_sel_out", 32'(CSR_sel_out), 32'(e.csr));
      chk("instr_out", instr_out, e.instr);
      chk("bus_err", 32'(bus_err), 32'(e.err));
      chk("misalign_exc", 32'(misalign_exc), 32'(e.mis));
    end
  endtask

  // Called at a negedge; returns at a negedge with the inputs idle.
  task automatic run_txn(input vec_t v, input logic [31:0] ins, input int max_cyc,
                         input logic exp_err, output int stalls);
    exp_t e;
    bit   done;
    stalls = 0;
    done   = 0;
    e.wb = v.exp_wb; e.regwrite = v.exp_regwrite; e.rd = v.rd; e.csr = v.csr;
    e.instr = ins; e.err = exp_err; e.mis = v.exp_mis; e.chk_wb = v.chk_wb;
    sb.push_back(e);
    alures_in = v.alures; MemWHB_in = v.whb; MemReWr_in = v.rw; RegVal2_in = v.val2;
    alu_res_pc4_in = v.pc4; pcadd4_in = v.pcadd4; RegWrite_in = v.regwrite;
    RdAddr_in = v.rd; CSR_sel_in = v.csr; instr_in = ins;
    for (int k = 1; k <= max_cyc && !done; k++) begin
      bus.dmem_gnt    = (k == v.gnt_cyc);
      bus.dmem_rvalid = (k == v.rv_cyc);
      bus.dmem_rdata  = v.rdata;
      #1;
      if (k == 1) begin
        chk("dmem_req", 32'(bus.dmem_req), 32'(v.exp_req));
        if (v.exp_req) begin
          chk("dmem_addr", bus.dmem_addr, v.exp_addr);
          chk("dmem_be", 32'(bus.dmem_be), 32'(v.exp_be));
          chk("dmem_wdata", bus.dmem_wdata, v.exp_wdata);
          chk("dmem_we", 32'(bus.dmem_we), 32'(v.rw == 2'b10));
        end
      end
      if (stall) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
      if (done) pop_check();
      @(negedge clk);
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL retire_bound: got no retire in %0d cycles expected a retire", max_cyc);
      sb.delete();
    end
    MemReWr_in = 2'b00; RegWrite_in = 1'b0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    vec_t tv;

    //          alures        whb     rw     val2          pc4   pcadd4 rwen rd csr gnt rv rdata          req addr       be       wdata         st wb             rw  mis cw
    vecs[0]  = '{32'h1234,   3'b010, 2'b00, 32'h0,        1'b0, 32'h8,  1'b1, 5, 1'b0, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,        0, 32'h1234,      1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h103,    3'b000, 2'b10, 32'hAB,       1'b0, 32'h10, 1'b0, 0, 1'b0, 1, 0, 32'h0,         1'b1, 32'h100, 4'b1000, 32'hABABABAB, 0, 32'h103,       1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32'h102,    3'b000, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 7, 1'b0, 3, 6, 32'h00800000,  1'b1, 32'h100, 4'b0100, 32'h0,        5, 32'hFFFFFF80,  1'b1, 1'b0, 1'b1};
    vecs[3]  = '{32'h102,    3'b100, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 8, 1'b0, 3, 6, 32'h00800000,  1'b1, 32'h100, 4'b0100, 32'h0,        5, 32'h00000080,  1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'h999,    3'b010, 2'b00, 32'h0,        1'b1, 32'h44, 1'b1, 1, 1'b1, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,        0, 32'h44,        1'b1, 1'b0, 1'b1};
`ifdef MISALIGN_TRAP_EN
    vecs[5]  = '{32'h102,    3'b010, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 9, 1'b0, 1, 2, 32'hDEADBEEF,  1'b0, 32'h0,   4'h0,    32'h0,        0, 32'h0,         1'b0, 1'b1, 1'b0};
`else
    vecs[5]  = '{32'h102,    3'b010, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 9, 1'b0, 1, 2, 32'hDEADBEEF,  1'b1, 32'h100, 4'b1111, 32'h0,        1, 32'hDEADBEEF,  1'b1, 1'b0, 1'b1};
`endif
    vecs[6]  = '{32'h106,    3'b001, 2'b10, 32'h1234ABCD, 1'b0, 32'h0,  1'b0, 0, 1'b0, 2, 0, 32'h0,         1'b1, 32'h104, 4'b1100, 32'hABCDABCD, 1, 32'h106,       1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h202,    3'b001, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 10, 1'b0, 1, 3, 32'h80010000, 1'b1, 32'h200, 4'b1100, 32'h0,        2, 32'hFFFF8001,  1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h202,    3'b101, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 11, 1'b0, 1, 3, 32'h80010000, 1'b1, 32'h200, 4'b1100, 32'h0,        2, 32'h00008001,  1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h101,    3'b000, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 12, 1'b0, 1, 2, 32'h00007F00, 1'b1, 32'h100, 4'b0010, 32'h0,        1, 32'h0000007F,  1'b1, 1'b0, 1'b1};
    vecs[10] = '{32'h20,     3'b010, 2'b10, 32'hCAFEF00D, 1'b0, 32'h0,  1'b0, 0, 1'b0, 1, 0, 32'h0,         1'b1, 32'h20,  4'b1111, 32'hCAFEF00D, 0, 32'h20,        1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h300,    3'b011, 2'b01, 32'h0,        1'b0, 32'h0,  1'b1, 13, 1'b1, 2, 4, 32'h12345678, 1'b1, 32'h300, 4'b1111, 32'h0,        3, 32'h12345678,  1'b1, 1'b0, 1'b1};
    vecs[12] = '{32'h77,     3'b010, 2'b11, 32'h0,        1'b0, 32'h0,  1'b1, 3, 1'b0, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,        0, 32'h77,        1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    alures_in = 32'h0; MemWHB_in = 3'b0; MemReWr_in = 2'b00; RegVal2_in = 32'h0;
    alu_res_pc4_in = 1'b0; pcadd4_in = 32'h0; RegWrite_in = 1'b0; RdAddr_in = 5'd0;
    CSR_sel_in = 1'b0; instr_in = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_wb_data_out", wb_data_out, 32'h0);
    chk("reset_RegWrite_out", 32'(RegWrite_out), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i], 32'h1000_0000 + 32'(i), 40, 1'b0, st);
      chk("stall_cycles", 32'(st), 32'(vecs[i].exp_stall));
      $display("txn %0d: alures=0x%08h rw=%b whb=%b stalls=%0d wb=0x%08h", i, vecs[i].alures,
               vecs[i].rw, vecs[i].whb, st, wb_data_out);
    end

    // Granted load that never sees rvalid: aborted by the timeout.
    tv = '{32'h40, 3'b010, 2'b01, 32'h0, 1'b0, 32'h0, 1'b1, 14, 1'b0, 1, 0, 32'h0,
           1'b1, 32'h40, 4'b1111, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0};
    run_txn(tv, 32'h2000_0000, 400, 1'b1, st);
    checks++;
    if (st < 255 || st > 257) begin
      errors++;
      $display("FAIL timeout_stalls: got %0d expected about 256", st);
    end
    $display("txn timeout: stalls=%0d bus_err=%b RegWrite_out=%b", st, bus_err, RegWrite_out);

    // Late rvalid after the abort must not disturb the next ALU op.
    tv = '{32'h55, 3'b010, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 15, 1'b0, 0, 1, 32'hBADBAD00,
           1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h55, 1'b1, 1'b0, 1'b1};
    run_txn(tv, 32'h2000_0001, 10, 1'b0, st);
    chk("late_rvalid_stalls", 32'(st), 32'h0);
    $display("txn late_rvalid: stalls=%0d wb=0x%08h", st, wb_data_out);

    // Reset asserted while a load waits for rvalid.
    alures_in = 32'h80; MemWHB_in = 3'b010; MemReWr_in = 2'b01; RegWrite_in = 1'b1;
    RdAddr_in = 5'd16; instr_in = 32'h3000_0000;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_be", 32'(bus.dmem_be), 32'h0);
    chk("rst_wb", wb_data_out, 32'h0);
    chk("rst_RdAddr", 32'(RdAddr_out), 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    MemReWr_in = 2'b00; RegWrite_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tv = '{32'hABC, 3'b010, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 17, 1'b0, 0, 5, 32'h11111111,
           1'b0, 32'h0, 4'h0, 32'h0, 0, 32'hABC, 1'b1, 1'b0, 1'b1};
    run_txn(tv, 32'h3000_0001, 10, 1'b0, st);
    chk("post_reset_stalls", 32'(st), 32'h0);
    $display("txn post_reset: stalls=%0d wb=0x%08h", st, wb_data_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
